ps2_key_tracker: RTL
====================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000000, giving the prefix-stall timeout in clock cycles (26-bit counter).
REQ-002 SHALL have port CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ps2_byte  in  8  received scan-code byte from the PS/2 controller.
REQ-005 SHALL have port ps2_byte_valid  in  1  one-cycle strobe qualifying ps2_byte.
REQ-006 SHALL have port o_l, o_r, o_u, o_d  out  1 each  arbitrated held-direction flags.
REQ-007 SHALL have port held  out  4  raw held bitmap {down, up, right, left}.
REQ-008 SHALL have port event_valid  out  1  one-cycle strobe per completed scan code.
REQ-009 SHALL have port event_code  out  8  final code byte of that scan code.
REQ-010 SHALL have ports event_break and event_ext  out  1 each  release flag and E0-prefix flag for that scan code.
REQ-011 SHALL have port last_byte  out  8  last accepted byte, for 7-seg display.
REQ-012 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-013 SHALL act only on cycles with ps2_byte_valid=1; other cycles hold all state except event_valid, which returns to 0.
REQ-014 SHALL implement FSM states IDLE, EXT, BRK, EXT_BRK.
REQ-015 IDLE: E0->EXT; F0->BRK; AA/FA/EE/FC/FE/00/FF ignored (no event); other->emit make, stay IDLE.
REQ-016 EXT: F0->EXT_BRK; E0->set err, stay EXT; other->emit make with event_ext=1, go IDLE.
REQ-017 BRK: E0 or F0->set err, go IDLE, no event; other->emit break, go IDLE.
REQ-018 EXT_BRK: E0 or F0->set err, go IDLE, no event; other->emit break with event_ext=1, go IDLE.
REQ-019 Emit SHALL assert event_valid for exactly one cycle, on the clock edge after the final byte's strobe, with event_code/event_break/event_ext registered together and held until the next emit.
REQ-020 Direction codes 6B=left, 74=right, 75=up, 72=down SHALL update held on the same edge as the emit, with or without E0: make sets the bit, break clears it.
REQ-021 Make of an already-held key (typematic repeat) SHALL emit an event and leave held unchanged.
REQ-022 o_l/o_r: when exactly one of left/right is held, that flag SHALL be 1. When both are held, only the most recently made one SHALL be 1. When the winner is released, the other SHALL take over on the same edge if still held.
REQ-023 o_u/o_d SHALL use the same last-pressed-wins arbitration as o_l/o_r.
REQ-024 last_byte SHALL update with every valid byte, including prefixes and ignored bytes.
REQ-025 err SHALL stay 1 once set, until reset.

Reset
REQ-026 On resetn=0, asynchronously: state=IDLE; held, o_l, o_r, o_u, o_d, event_valid, event_code, event_break, event_ext, last_byte, err, timeout counter and arbitration registers all 0.
REQ-027 Reset mid-sequence (for example after E0 F0) SHALL discard the partial code; the first byte after reset is parsed from IDLE.

Configuration
REQ-028 Macro PS2_KEY_TRACKER_TIMEOUT_EN defined: in any state other than IDLE, the counter SHALL increment each cycle without a valid byte and clear on a valid byte.
REQ-029 With the macro, a count reaching TIMEOUT_CYCLES SHALL force IDLE, set err and emit no event.
REQ-030 Macro undefined: no counter logic; prefix states persist indefinitely; TIMEOUT_CYCLES SHALL be ignored.

Verification
REQ-031 Bytes E0,74 then E0,F0,74 -> event{74,brk=0,ext=1}, o_r=1; then event{74,brk=1,ext=1}, o_r=0, held=0000.
REQ-032 Make 6B, make 74, break 74 -> o_l=1,o_r=0; then o_l=0,o_r=1; then o_l=1,o_r=0; held[0] stays 1 throughout.
REQ-033 Bytes AA, FA, then 1C -> no event for AA/FA; event{1C,0,0}; last_byte=1C; held=0000.
REQ-034 Bytes F0,F0 -> err=1, state IDLE, no event; then 75 -> event{75,0,0}, o_u=1.
REQ-035 With TIMEOUT_EN and TIMEOUT_CYCLES=16: byte E0, idle 16 cycles, then 74 -> err=1, event{74,0,0}, ext=0.
REQ-036 Byte E0 then resetn pulsed low mid-cycle -> all outputs 0 immediately; then F0,74 -> break event with ext=0, no error.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// rtl/ps2_key_tracker_if.sv - byte input and key/event output bundle of the PS/2 key tracker
//
// Signals:
//   ps2_byte[7:0], ps2_byte_valid      scan-code byte and its one-cycle strobe (master -> slave)
//   o_l, o_r, o_u, o_d                 arbitrated held-direction flags (slave -> master)
//   held[3:0]                          raw held bitmap {down, up, right, left}
//   event_valid                        one-cycle strobe per completed scan code
//   event_code[7:0]                    final code byte of that scan code
//   event_break, event_ext             release flag and E0-prefix flag of that scan code
//   last_byte[7:0]                     last accepted byte
//   err                                sticky protocol-error flag
// Modports: master drives bytes and observes results, slave is the tracker.
interface ps2_key_tracker_if;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       o_l;
    logic       o_r;
    logic       o_u;
    logic       o_d;
    logic [3:0] held;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_break;
    logic       event_ext;
    logic [7:0] last_byte;
    logic       err;

    modport master (
        output ps2_byte, ps2_byte_valid,
        input  o_l, o_r, o_u, o_d, held,
        input  event_valid, event_code, event_break, event_ext,
        input  last_byte, err
    );

    modport slave (
        input  ps2_byte, ps2_byte_valid,
        output o_l, o_r, o_u, o_d, held,
        output event_valid, event_code, event_break, event_ext,
        output last_byte, err
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 scan-code parser with held-direction tracking and arbitration
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   bus        ps2_key_tracker_if.slave (byte input, direction flags, event outputs, last_byte, err)
// Parameter:
//   TIMEOUT_CYCLES  prefix-stall timeout in clock cycles (26-bit counter)
// Optional feature macro:
//   PS2_KEY_TRACKER_TIMEOUT_EN  when defined, a stalled prefix (E0/F0) returns to IDLE after
//                               TIMEOUT_CYCLES idle cycles and sets err; otherwise prefixes persist.
module ps2_key_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    ps2_key_tracker_if.slave       bus
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t     state;
    state_t     state_n;

    logic       emit;
    logic       emit_brk;
    logic       emit_ext;
    logic       proto_err;
    logic       timeout_hit;
    logic       byte_ignored;
    logic       is_ext;
    logic       is_brk;

    logic [3:0] held;
    logic [3:0] held_n;
    logic [3:0] dir_sel;
    logic [3:0] newly_pressed;
    // 1 = right (resp. down) was the most recent new press of its pair
    logic       last_lr;
    logic       last_ud;
    logic       last_lr_n;
    logic       last_ud_n;

    logic       event_valid_q;
    logic [7:0] event_code_q;
    logic       event_break_q;
    logic       event_ext_q;
    logic [7:0] last_byte_q;
    logic       err_q;

    assign is_ext = (bus.ps2_byte == CODE_EXT);
    assign is_brk = (bus.ps2_byte == CODE_BRK);

    // Controller/keyboard housekeeping bytes that never form a key event from IDLE
    always_comb begin
        byte_ignored = 1'b0;
        case (bus.ps2_byte)
            8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: byte_ignored = 1'b1;
            default:                                         byte_ignored = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Prefix stall timeout
    // ------------------------------------------------------------------
`ifdef PS2_KEY_TRACKER_TIMEOUT_EN
    localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);

    logic [25:0] tmo_cnt;

    // The hit fires on the idle cycle that would bring the count to TIMEOUT_CYCLES
    assign timeout_hit = (state != IDLE) && !bus.ps2_byte_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if ((state == IDLE) || bus.ps2_byte_valid || timeout_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 26'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^(26'(TIMEOUT_CYCLES));
`endif

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        emit      = 1'b0;
        emit_brk  = 1'b0;
        emit_ext  = 1'b0;
        proto_err = 1'b0;
        if (bus.ps2_byte_valid) begin
            case (state)
                IDLE: begin
                    if (is_ext) begin
                        state_n = EXT;
                    end else if (is_brk) begin
                        state_n = BRK;
                    end else if (!byte_ignored) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (is_brk) begin
                        state_n = EXT_BRK;
                    end else if (is_ext) begin
                        // Doubled E0: flag it but keep waiting for the code byte
                        proto_err = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_n  = IDLE;
                    end
                end
                BRK: begin
                    state_n = IDLE;
                    if (is_ext || is_brk) begin
                        proto_err = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                    end
                end
                EXT_BRK: begin
                    state_n = IDLE;
                    if (is_ext || is_brk) begin
                        proto_err = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_n   = IDLE;
            proto_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Held bitmap and last-pressed-wins arbitration
    // ------------------------------------------------------------------
    always_comb begin
        dir_sel = 4'b0000;
        case (bus.ps2_byte)
            CODE_LEFT:  dir_sel = 4'b0001;
            CODE_RIGHT: dir_sel = 4'b0010;
            CODE_UP:    dir_sel = 4'b0100;
            CODE_DOWN:  dir_sel = 4'b1000;
            default:    dir_sel = 4'b0000;
        endcase
    end

    always_comb begin
        held_n        = held;
        last_lr_n     = last_lr;
        last_ud_n     = last_ud;
        newly_pressed = 4'b0000;
        if (emit) begin
            if (emit_brk) begin
                held_n = held & ~dir_sel;
            end else begin
                held_n = held | dir_sel;
                // Typematic repeats of an already-held key do not steal priority
                newly_pressed = dir_sel & ~held;
            end
        end
        if (newly_pressed[0]) last_lr_n = 1'b0;
        if (newly_pressed[1]) last_lr_n = 1'b1;
        if (newly_pressed[2]) last_ud_n = 1'b0;
        if (newly_pressed[3]) last_ud_n = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            held    <= 4'b0000;
            last_lr <= 1'b0;
            last_ud <= 1'b0;
        end else begin
            held    <= held_n;
            last_lr <= last_lr_n;
            last_ud <= last_ud_n;
        end
    end

    // When the winner is released its partner, if still held, wins by falling through
    assign bus.o_l  = held[0] & (~held[1] | ~last_lr);
    assign bus.o_r  = held[1] & (~held[0] |  last_lr);
    assign bus.o_u  = held[2] & (~held[3] | ~last_ud);
    assign bus.o_d  = held[3] & (~held[2] |  last_ud);
    assign bus.held = held;

    // ------------------------------------------------------------------
    // Event, last byte and error registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            event_valid_q <= 1'b0;
            event_code_q  <= 8'h00;
            event_break_q <= 1'b0;
            event_ext_q   <= 1'b0;
            last_byte_q   <= 8'h00;
            err_q         <= 1'b0;
        end else begin
            event_valid_q <= emit;
            if (emit) begin
                event_code_q  <= bus.ps2_byte;
                event_break_q <= emit_brk;
                event_ext_q   <= emit_ext;
            end
            if (bus.ps2_byte_valid) begin
                last_byte_q <= bus.ps2_byte;
            end
            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.event_valid = event_valid_q;
    assign bus.event_code  = event_code_q;
    assign bus.event_break = event_break_q;
    assign bus.event_ext   = event_ext_q;
    assign bus.last_byte   = last_byte_q;
    assign bus.err         = err_q;

endmodule
